ecc_scrub_ctrl: RTL

//  Front-end controller for one ecc_ram instance; arbitrates host access against a background scrubber.
//  The scrubber periodically reads each word and writes back corrected data on a single-bit error.
//  It also counts single-/double-bit errors and raises a sticky interrupt on any double-bit error.

---
 rtl/ecc_ram_pkg.sv | 15 +
 rtl/ecc_sat_counter.sv | 33 +++
 rtl/ecc_scrub_ctrl.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/ecc_ram_pkg.sv
// Shared types for the ECC RAM scrub controller: FSM states and address sizing.
package ecc_ram_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SRD  = 2'd1,
        ST_SCHK = 2'd2,
        ST_SWB  = 2'd3
    } scrub_state_e;

    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/ecc_sat_counter.sv
// Saturating up-counter; an increment coinciding with a clear restarts at one.
module ecc_sat_counter #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inc_i,
    input  logic                 clr_i,
    output logic [CNT_WIDTH-1:0] cnt_o
);

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i) begin
            if (clr_i)
                cnt_d = CNT_WIDTH'(1);
            else if (!(&cnt_q))
                cnt_d = cnt_q + 1'b1;
        end else if (clr_i) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/ecc_scrub_ctrl.sv
// Host/scrubber arbiter and error accounting in front of one ecc_ram.
// Optional ECC_SCRUB_LOG_EN adds last_err_addr / last_err_dbe.
module ecc_scrub_ctrl
    import ecc_ram_pkg::*;
#(
    parameter int DATA_WIDTH     = 16,
    parameter int RAM_DEPTH      = 64,
    parameter int SCRUB_INTERVAL = 1024,
    parameter int CNT_WIDTH      = 16,
    localparam int ADDR_WIDTH    = addr_width(RAM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  host_req,
    input  logic                  host_we,
    input  logic [ADDR_WIDTH-1:0] host_addr,
    input  logic [DATA_WIDTH-1:0] host_wdata,
    output logic                  host_gnt,
    output logic                  host_rvalid,
    output logic [DATA_WIDTH-1:0] host_rdata,
    input  logic                  scrub_en,
    input  logic                  err_clr,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_data_in,
    output logic                  ram_write_en,
    output logic                  ram_read_en,
    input  logic [DATA_WIDTH-1:0] ram_data_out,
    input  logic                  ram_sbe,
    input  logic                  ram_dbe,
    output logic [CNT_WIDTH-1:0]  sbe_count,
    output logic [CNT_WIDTH-1:0]  dbe_count,
    output logic                  irq_dbe,
    output logic                  scrub_busy,
`ifdef ECC_SCRUB_LOG_EN
    output logic [ADDR_WIDTH-1:0] last_err_addr,
    output logic                  last_err_dbe,
`endif
    output logic                  pass_done
);

    localparam int IW = $clog2(SCRUB_INTERVAL);
    localparam logic [IW-1:0] IV_LAST = IW'(SCRUB_INTERVAL - 1);
    localparam logic [ADDR_WIDTH-1:0] A_LAST = ADDR_WIDTH'(RAM_DEPTH - 1);

    scrub_state_e          state_q, state_d;
    logic [IW-1:0]         ivl_q, ivl_d;
    logic [ADDR_WIDTH-1:0] saddr_q, saddr_d;
    logic [DATA_WIDTH-1:0] wb_q, wb_d;
    logic                  hrd_q, hrd_d;
    logic                  pass_q, pass_d;
    logic                  irq_q, irq_d;
    logic                  scrub_pend, chk, advance;
    logic                  sbe_inc, dbe_inc;

    // Pending is gated by scrub_en so a disabled scrubber never blocks the host.
    assign scrub_pend = scrub_en && (ivl_q == IV_LAST);
    assign chk        = hrd_q || (state_q == ST_SCHK);
    assign sbe_inc    = chk && ram_sbe;
    assign dbe_inc    = chk && ram_dbe;

    always_comb begin
        state_d      = state_q;
        ivl_d        = ivl_q;
        saddr_d      = saddr_q;
        wb_d         = wb_q;
        host_gnt     = 1'b0;
        ram_addr     = '0;
        ram_data_in  = '0;
        ram_write_en = 1'b0;
        ram_read_en  = 1'b0;
        advance      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (scrub_pend) begin
                    state_d = ST_SRD;
                    ivl_d   = '0;
                end else begin
                    if (scrub_en) ivl_d = ivl_q + 1'b1;
                    host_gnt = host_req && !rst;
                    if (host_gnt) begin
                        ram_addr     = host_addr;
                        ram_write_en = host_we;
                        ram_read_en  = !host_we;
                        ram_data_in  = host_we ? host_wdata : '0;
                    end
                end
            end
            ST_SRD: begin
                ram_addr    = saddr_q;
                ram_read_en = 1'b1;
                state_d     = ST_SCHK;
            end
            ST_SCHK: begin
                wb_d = ram_data_out;
                if (ram_sbe && !ram_dbe) begin
                    state_d = ST_SWB;
                end else begin
                    state_d = ST_IDLE;
                    advance = 1'b1;
                end
            end
            ST_SWB: begin
                ram_addr     = saddr_q;
                ram_data_in  = wb_q;
                ram_write_en = 1'b1;
                state_d      = ST_IDLE;
                advance      = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
        if (advance)
            saddr_d = (saddr_q == A_LAST) ? '0 : saddr_q + 1'b1;
    end

    assign hrd_d  = host_gnt && !host_we;
    assign pass_d = advance && (saddr_q == A_LAST);
    assign irq_d  = dbe_inc ? 1'b1 : (err_clr ? 1'b0 : irq_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ivl_q   <= '0;
            saddr_q <= '0;
            wb_q    <= '0;
            hrd_q   <= 1'b0;
            pass_q  <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ivl_q   <= ivl_d;
            saddr_q <= saddr_d;
            wb_q    <= wb_d;
            hrd_q   <= hrd_d;
            pass_q  <= pass_d;
            irq_q   <= irq_d;
        end
    end

    ecc_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_sbe_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (sbe_inc),
        .clr_i (err_clr),
        .cnt_o (sbe_count)
    );

    ecc_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_dbe_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (dbe_inc),
        .clr_i (err_clr),
        .cnt_o (dbe_count)
    );

`ifdef ECC_SCRUB_LOG_EN
    logic [ADDR_WIDTH-1:0] haddr_q, lea_q;
    logic                  led_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            haddr_q <= '0;
            lea_q   <= '0;
            led_q   <= 1'b0;
        end else begin
            if (hrd_d) haddr_q <= host_addr;
            if (sbe_inc || dbe_inc) begin
                lea_q <= hrd_q ? haddr_q : saddr_q;
                led_q <= ram_dbe;
            end
        end
    end

    assign last_err_addr = lea_q;
    assign last_err_dbe  = led_q;
`endif

    assign host_rvalid = hrd_q;
    assign host_rdata  = hrd_q ? ram_data_out : '0;
    assign irq_dbe     = irq_q;
    assign scrub_busy  = (state_q != ST_IDLE);
    assign pass_done   = pass_q;

endmodule
